decimator: RTL

Polyphase-style FIR decimator: accepts input samples through a valid/ready handshake and runs them through an NTAPS-tap FIR filter. It emits one filtered output sample for every DOWNFACTOR accepted inputs. It is the receive-side counterpart of the interpolator: it takes the upsampled stream back down to the slow rate. A single time-shared multiply-accumulate unit computes each output, and the block stalls its input while the MAC runs.

---
 rtl/decimator.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/decimator.sv
// FIR decimator: accepts samples over valid/ready and emits one filtered output
// per DOWNFACTOR accepted inputs, using one time-shared MAC while input stalls.
module decimator #(
  parameter int DOWNFACTOR = 5,
  parameter int NTAPS      = 30,
  parameter int IW         = 16,
  parameter int TW         = 16,
  parameter int OW         = IW + TW
) (
  input  logic                     i_clk,
  input  logic                     i_reset_n,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic [IW-1:0]            i_sample,
  input  logic                     i_tap_wr,
  input  logic [$clog2(NTAPS)-1:0] i_tap_addr,
  input  logic [TW-1:0]            i_tap,
  output logic                     o_valid,
  output logic [OW-1:0]            o_result
);

  localparam int AB = $clog2(NTAPS);
  localparam int PB = (DOWNFACTOR > 2) ? $clog2(DOWNFACTOR) : 1;
  localparam int AW = IW + TW + AB;
  localparam logic [AB-1:0] LAST_TAP = AB'(NTAPS - 1);
  localparam logic [PB-1:0] LAST_PH  = PB'(DOWNFACTOR - 1);

  typedef enum logic {IDLE = 1'b0, MAC = 1'b1} state_t;

  state_t               state_q, state_d;
  logic                 ready_q, ready_d;
  logic                 valid_q, valid_d;
  logic [AB-1:0]        k_q, k_d;
  logic [PB-1:0]        phase_q;
  logic signed [AW-1:0] acc_q, acc_d;
  logic [OW-1:0]        result_q, result_d;
  logic signed [IW-1:0] x_q [NTAPS];
  logic signed [TW-1:0] h_q [NTAPS];

  logic                   accept_s;
  logic                   trigger_s;
  logic                   tap_we_s;
  logic signed [IW+TW-1:0] prod_s;
  logic signed [AW-1:0]   base_s;
  logic signed [AW-1:0]   sum_s;
  logic [OW-1:0]          sat_s;

  assign accept_s  = i_valid && ready_q;
  assign trigger_s = accept_s && (phase_q == LAST_PH);
  assign tap_we_s  = i_tap_wr && (state_q == IDLE) && (i_tap_addr <= LAST_TAP);
  assign prod_s    = x_q[k_q] * h_q[k_q];

  // MAC step: the first tap restarts the accumulation
  always_comb begin
    if (k_q == {AB{1'b0}}) begin
      base_s = {AW{1'b0}};
    end else begin
      base_s = acc_q;
    end
    sum_s = base_s + AW'(prod_s);
  end

  generate
    if (OW >= AW) begin : g_ext
      assign sat_s = OW'(sum_s);
    end else begin : g_sat
      localparam logic signed [AW-1:0] MAX_V = AW'({1'b0, {(OW-1){1'b1}}});
      localparam logic signed [AW-1:0] MIN_V = ~MAX_V;
      // Clamp the wide accumulator into the output range
      always_comb begin
        if (sum_s > MAX_V) begin
          sat_s = {1'b0, {(OW-1){1'b1}}};
        end else if (sum_s < MIN_V) begin
          sat_s = {1'b1, {(OW-1){1'b0}}};
        end else begin
          sat_s = sum_s[OW-1:0];
        end
      end
    end
  endgenerate

  // Next-state and output decode
  always_comb begin
    state_d  = state_q;
    ready_d  = 1'b0;
    valid_d  = 1'b0;
    k_d      = k_q;
    acc_d    = acc_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        k_d = {AB{1'b0}};
        if (trigger_s) begin
          state_d = MAC;
          ready_d = 1'b0;
        end else begin
          state_d = IDLE;
          ready_d = 1'b1;
        end
      end
      MAC: begin
        acc_d = sum_s;
        if (k_q == LAST_TAP) begin
          state_d  = IDLE;
          ready_d  = 1'b1;
          valid_d  = 1'b1;
          result_d = sat_s;
          k_d      = {AB{1'b0}};
        end else begin
          k_d = k_q + AB'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q  <= IDLE;
      ready_q  <= 1'b0;
      valid_q  <= 1'b0;
      k_q      <= {AB{1'b0}};
      acc_q    <= {AW{1'b0}};
      result_q <= {OW{1'b0}};
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
      k_q      <= k_d;
      acc_q    <= acc_d;
      result_q <= result_d;
    end
  end

  // Delay line and phase advance on every accepted sample
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      phase_q <= {PB{1'b0}};
      for (int i = 0; i < NTAPS; i++) begin
        x_q[i] <= {IW{1'b0}};
      end
    end else if (accept_s) begin
      x_q[0] <= i_sample;
      for (int i = 1; i < NTAPS; i++) begin
        x_q[i] <= x_q[i-1];
      end
      if (trigger_s) begin
        phase_q <= {PB{1'b0}};
      end else begin
        phase_q <= phase_q + PB'(1);
      end
    end
  end

  // Coefficient memory; frozen while a MAC pass is reading it
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      for (int i = 0; i < NTAPS; i++) begin
        h_q[i] <= {TW{1'b0}};
      end
    end else if (tap_we_s) begin
      h_q[i_tap_addr] <= i_tap;
    end
  end

  assign o_ready  = ready_q;
  assign o_valid  = valid_q;
  assign o_result = result_q;

endmodule
